toy_commit_queue: RTL and testbench

In-order commit queue that receives instructions from the fetch queue read channels and tracks their completion. It retires up to CMT_CH instructions per cycle in program order, and returns freed slots to the fetch queue through the commit credit release interface. The fetch queue's credit counter, which resets to DEPTH, guarantees this block never overflows.

---
 rtl/toy_commit_queue_if.sv | 49 ++++
 rtl/toy_commit_queue.sv | 190 +++++++++++++++++++
 tb/tb_toy_commit_queue.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_commit_queue_if.sv
// toy_commit_queue_if
//   Bundles the fetch-to-commit signals of toy_commit_queue.
//   master = fetch side / environment, slave = commit queue.
//
//   cancel_en             flush strobe, same cycle as the fetch queue cancel
//   v_in_vld/rdy/idx/pc   per-lane instruction allocation
//   v_cmpl_en/idx         completion reports
//   v_cmt_vld/pc/idx      retired instructions, lanes contiguous from lane 0
//   commit_credit_rel_*   credits returned to the fetch queue
//   seq_err               sticky index-sequence error
//
// Handshake: a lane transfers in a cycle where v_in_vld[i] and v_in_rdy[i] are
// both high at the rising clk edge. v_in_rdy does not depend on v_in_vld. The
// sender must not raise v_in_vld without a fetch-queue credit, so the queue
// never stalls for capacity. v_cmpl_* and v_cmt_* are fire-and-forget: there
// is no back-pressure on them.
interface toy_commit_queue_if #(
  parameter int IN_CH   = 8,
  parameter int CMPL_CH = 4,
  parameter int CMT_CH  = 4,
  parameter int IDX_W   = 8,
  parameter int ADDR_W  = 32
);
  logic                           cancel_en;
  logic [IN_CH-1:0]               v_in_vld;
  logic [IN_CH-1:0]               v_in_rdy;
  logic [IN_CH-1:0][IDX_W-1:0]    v_in_idx;
  logic [IN_CH-1:0][ADDR_W-1:0]   v_in_pc;
  logic [CMPL_CH-1:0]             v_cmpl_en;
  logic [CMPL_CH-1:0][IDX_W-1:0]  v_cmpl_idx;
  logic [CMT_CH-1:0]              v_cmt_vld;
  logic [CMT_CH-1:0][ADDR_W-1:0]  v_cmt_pc;
  logic [CMT_CH-1:0][IDX_W-1:0]   v_cmt_idx;
  logic                           commit_credit_rel_en;
  logic [2:0]                     commit_credit_rel_num;
  logic                           seq_err;

  modport master (
    output cancel_en, v_in_vld, v_in_idx, v_in_pc, v_cmpl_en, v_cmpl_idx,
    input  v_in_rdy, v_cmt_vld, v_cmt_pc, v_cmt_idx,
           commit_credit_rel_en, commit_credit_rel_num, seq_err
  );

  modport slave (
    input  cancel_en, v_in_vld, v_in_idx, v_in_pc, v_cmpl_en, v_cmpl_idx,
    output v_in_rdy, v_cmt_vld, v_cmt_pc, v_cmt_idx,
           commit_credit_rel_en, commit_credit_rel_num, seq_err
  );
endinterface

// File: rtl/toy_commit_queue.sv
// toy_commit_queue
//   In-order commit queue. Instructions are written into the slot selected by
//   their index (idx mod DEPTH), marked done by completion reports, and retired
//   in program order, up to CMT_CH per cycle. Each retirement returns the
//   freed slots to the fetch queue as credits.
//
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    toy_commit_queue_if.slave (allocation, completion, retire, credits,
//          cancel, seq_err)
module toy_commit_queue #(
  parameter int DEPTH   = 32,
  parameter int IN_CH   = 8,
  parameter int CMPL_CH = 4,
  parameter int CMT_CH  = 4,
  parameter int IDX_W   = 8,
  parameter int ADDR_W  = 32
) (
  input logic                clk,
  input logic                rst_n,
  toy_commit_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0]              done_q, done_d;
  logic [ADDR_W-1:0]             pc_q  [DEPTH];
  logic [IDX_W-1:0]              idx_q [DEPTH];
  ptr_t                          head_q, head_d;
  logic [IDX_W-1:0]              exp_idx_q, exp_idx_d;
  logic                          seq_err_q, seq_err_d;
  logic [CMT_CH-1:0]             cmt_vld_q, cmt_vld_d;
  logic [CMT_CH-1:0][ADDR_W-1:0] cmt_pc_q, cmt_pc_d;
  logic [CMT_CH-1:0][IDX_W-1:0]  cmt_idx_q, cmt_idx_d;
  logic                          rel_en_q, rel_en_d;
  logic [2:0]                    rel_num_q, rel_num_d;

  logic [IN_CH-1:0] in_acc;
  logic [IDX_W-1:0] acc_cnt;
  logic             seq_bad;
  logic [2:0]       ret_n;
  logic [DEPTH-1:0] ret_mask;
  logic             alloc_conflict;

  // Capacity is guaranteed by the sender's credits; only a flush blocks input.
  assign bus.v_in_rdy = {IN_CH{~bus.cancel_en}};
  assign in_acc       = bus.v_in_vld & bus.v_in_rdy;

  // Retire window: run of valid&done slots starting at head, from registered
  // state only, stopping at the first slot that is not ready.
  always_comb begin
    ptr_t slot;
    logic stop;
    ret_n    = '0;
    ret_mask = '0;
    stop     = 1'b0;
    for (int i = 0; i < CMT_CH; i++) begin
      slot = head_q + ptr_t'(i);
      if (!stop && valid_q[slot] && done_q[slot]) begin
        ret_n          = ret_n + 3'd1;
        ret_mask[slot] = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Accepted lanes, taken in ascending lane order, must form a consecutive
  // index run starting at exp_idx_q; gaps between active lanes are allowed.
  always_comb begin
    acc_cnt = '0;
    seq_bad = 1'b0;
    for (int l = 0; l < IN_CH; l++) begin
      if (in_acc[l]) begin
        if (bus.v_in_idx[l] != exp_idx_q + acc_cnt) seq_bad = 1'b1;
        acc_cnt = acc_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ptr_t cslot;
    ptr_t aslot;
    ptr_t rslot;
    valid_d        = valid_q;
    done_d         = done_q;
    head_d         = head_q;
    exp_idx_d      = exp_idx_q;
    seq_err_d      = seq_err_q;
    cmt_vld_d      = '0;
    cmt_pc_d       = '0;
    cmt_idx_d      = '0;
    rel_en_d       = 1'b0;
    rel_num_d      = '0;
    alloc_conflict = 1'b0;
    cslot          = '0;
    aslot          = '0;
    rslot          = '0;
    if (bus.cancel_en) begin
      // Flush drops the retirement decided this cycle: the sender resets its
      // credit count to DEPTH, so no credit may be released for it.
      valid_d   = '0;
      done_d    = '0;
      head_d    = '0;
      exp_idx_d = '0;
      seq_err_d = 1'b0;
    end else begin
      // Completions only hit a live slot holding the same full index, so a
      // report for an older lap of the ring is ignored.
      for (int k = 0; k < CMPL_CH; k++) begin
        cslot = bus.v_cmpl_idx[k][PTR_W-1:0];
        if (bus.v_cmpl_en[k] && valid_q[cslot] && (idx_q[cslot] == bus.v_cmpl_idx[k]))
          done_d[cslot] = 1'b1;
      end
      valid_d   = valid_d & ~ret_mask;
      done_d    = done_d & ~ret_mask;
      head_d    = head_q + ptr_t'(ret_n);
      rel_en_d  = (ret_n != 3'd0);
      rel_num_d = ret_n;
      for (int i = 0; i < CMT_CH; i++) begin
        rslot = head_q + ptr_t'(i);
        if (3'(i) < ret_n) begin
          cmt_vld_d[i] = 1'b1;
          cmt_pc_d[i]  = pc_q[rslot];
          cmt_idx_d[i] = idx_q[rslot];
        end
      end
      // Allocation is applied last so it wins over a same-cycle completion.
      for (int l = 0; l < IN_CH; l++) begin
        if (in_acc[l]) begin
          aslot = bus.v_in_idx[l][PTR_W-1:0];
          if (valid_q[aslot]) alloc_conflict = 1'b1;
          valid_d[aslot] = 1'b1;
          done_d[aslot]  = 1'b0;
        end
      end
      if (|in_acc) begin
        exp_idx_d = exp_idx_q + acc_cnt;
        if (seq_bad) seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      done_q    <= '0;
      head_q    <= '0;
      exp_idx_q <= '0;
      seq_err_q <= 1'b0;
      cmt_vld_q <= '0;
      cmt_pc_q  <= '0;
      cmt_idx_q <= '0;
      rel_en_q  <= 1'b0;
      rel_num_q <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      head_q    <= head_d;
      exp_idx_q <= exp_idx_d;
      seq_err_q <= seq_err_d;
      cmt_vld_q <= cmt_vld_d;
      cmt_pc_q  <= cmt_pc_d;
      cmt_idx_q <= cmt_idx_d;
      rel_en_q  <= rel_en_d;
      rel_num_q <= rel_num_d;
    end
  end

  // Payload storage needs no reset: it is only read where valid_q is set.
  always_ff @(posedge clk) begin
    for (int l = 0; l < IN_CH; l++) begin
      if (in_acc[l]) begin
        pc_q[bus.v_in_idx[l][PTR_W-1:0]]  <= bus.v_in_pc[l];
        idx_q[bus.v_in_idx[l][PTR_W-1:0]] <= bus.v_in_idx[l];
      end
    end
  end

  assign bus.v_cmt_vld             = cmt_vld_q;
  assign bus.v_cmt_pc              = cmt_pc_q;
  assign bus.v_cmt_idx             = cmt_idx_q;
  assign bus.commit_credit_rel_en  = rel_en_q;
  assign bus.commit_credit_rel_num = rel_num_q;
  assign bus.seq_err               = seq_err_q;

  // Writing a live slot means the sender overran its credits.
  a_no_alloc_over_live : assert property (@(posedge clk) disable iff (!rst_n) !alloc_conflict);
endmodule

// File: tb/tb_toy_commit_queue.sv
module tb_toy_commit_queue;
  localparam int DEPTH   = 32;
  localparam int IN_CH   = 8;
  localparam int CMPL_CH = 4;
  localparam int CMT_CH  = 4;
  localparam int IDX_W   = 8;
  localparam int ADDR_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  toy_commit_queue_if #(
    .IN_CH(IN_CH), .CMPL_CH(CMPL_CH), .CMT_CH(CMT_CH), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) bus ();

  toy_commit_queue #(
    .DEPTH(DEPTH), .IN_CH(IN_CH), .CMPL_CH(CMPL_CH), .CMT_CH(CMT_CH),
    .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_vec     = 0;
  int n_miss    = 0;
  int total_rel = 0;
  // {expected output cycle[26:11], retire count[10:8], first index[7:0]}
  logic [26:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [7:0] idx);
    return 32'h1000 + {22'd0, idx, 2'b00};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr();
    bus.cancel_en  = 1'b0;
    bus.v_in_vld   = '0;
    bus.v_in_idx   = '0;
    bus.v_in_pc    = '0;
    bus.v_cmpl_en  = '0;
    bus.v_cmpl_idx = '0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic acc(input int lane, input int idx);
    bus.v_in_vld[lane] = 1'b1;
    bus.v_in_idx[lane] = IDX_W'(idx);
    bus.v_in_pc[lane]  = pc_of(8'(idx));
  endtask

  task automatic cmpl(input int port, input int idx);
    bus.v_cmpl_en[port]  = 1'b1;
    bus.v_cmpl_idx[port] = IDX_W'(idx);
  endtask

  task automatic expect_ret(input int at_cyc, input int n, input int base);
    exp_q.push_back({16'(at_cyc), 3'(n), 8'(base)});
  endtask

  task automatic do_reset();
    check("pending_before_reset", exp_q.size(), 0);
    exp_q.delete();
    clr();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [26:0]       e;
    int                en, eb, ec;
    logic [CMT_CH-1:0] m;
    logic [7:0]        ix;
    if (rst_n && ((|bus.v_cmt_vld) || bus.commit_credit_rel_en)) begin
      total_rel += int'(bus.commit_credit_rel_num);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_retire: got vld=%b rel_en=%b rel_num=%0d expected no retire (cycle %0d)",
                 bus.v_cmt_vld, bus.commit_credit_rel_en, bus.commit_credit_rel_num, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = int'(e[26:11]);
        en = int'(e[10:8]);
        eb = int'(e[7:0]);
        m  = '0;
        for (int i = 0; i < en; i++) m[i] = 1'b1;
        check("ret_cycle", cyc, ec);
        check("ret_vld", bus.v_cmt_vld, m);
        check("rel_en", bus.commit_credit_rel_en, 1);
        check("rel_num", bus.commit_credit_rel_num, en);
        for (int i = 0; i < en; i++) begin
          ix = 8'(eb + i);
          check("ret_idx", bus.v_cmt_idx[i], ix);
          check("ret_pc", bus.v_cmt_pc[i], pc_of(ix));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rel_base;
    clr();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_vld", bus.v_cmt_vld, 0);
    check("rst_rel_en", bus.commit_credit_rel_en, 0);
    check("rst_rel_num", bus.commit_credit_rel_num, 0);
    check("rst_rdy", bus.v_in_rdy, 8'hFF);
    check("rst_seq_err", bus.seq_err, 0);

    // single instruction, minimum latency
    acc(0, 0);
    tick();
    clr();
    cmpl(0, 0);
    tick();
    expect_ret(cyc + 1, 1, 0);
    clr();
    tick(4);

    // out-of-order completion behind an unfinished head
    do_reset();
    for (int l = 0; l < 8; l++) acc(l, l);
    tick();
    clr();
    cmpl(0, 1); cmpl(1, 2); cmpl(2, 3);
    tick();
    clr();
    tick(3);
    cmpl(0, 0);
    tick();
    expect_ret(cyc + 1, 4, 0);
    clr();
    tick(4);
    cmpl(0, 4);
    tick();
    expect_ret(cyc + 1, 1, 4);
    clr();
    tick(2);
    cmpl(0, 5); cmpl(1, 6); cmpl(2, 7);
    tick();
    expect_ret(cyc + 1, 3, 5);
    clr();
    tick(3);
    @(negedge clk);
    check("seq_ok_burst", bus.seq_err, 0);

    // full ring, 4 retires per cycle, head wrap and slot reuse
    do_reset();
    rel_base = total_rel;
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < 8; l++) acc(l, g * 8 + l);
      tick();
      clr();
    end
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < 4; p++) cmpl(p, g * 4 + p);
      tick();
      expect_ret(cyc + 1, 4, g * 4);
      clr();
    end
    tick(2);
    for (int l = 0; l < 8; l++) acc(l, 32 + l);
    tick();
    clr();
    for (int p = 0; p < 4; p++) cmpl(p, 32 + p);
    tick();
    expect_ret(cyc + 1, 4, 32);
    clr();
    for (int p = 0; p < 4; p++) cmpl(p, 36 + p);
    tick();
    expect_ret(cyc + 1, 4, 36);
    clr();
    tick(4);
    @(negedge clk);
    check("credit_total", total_rel - rel_base, 40);
    check("seq_ok_fill", bus.seq_err, 0);

    // sparse lanes and sequence error
    do_reset();
    acc(0, 0); acc(2, 1); acc(5, 2);
    tick();
    clr();
    @(negedge clk);
    check("seq_sparse", bus.seq_err, 0);
    acc(0, 4);
    tick();
    clr();
    @(negedge clk);
    check("seq_err_set", bus.seq_err, 1);
    tick(3);
    @(negedge clk);
    check("seq_err_sticky", bus.seq_err, 1);

    // cancel in the cycle a retirement is decided
    do_reset();
    for (int l = 0; l < 6; l++) acc(l, l);
    tick();
    clr();
    for (int p = 0; p < 4; p++) cmpl(p, p);
    acc(7, 9);
    tick();
    clr();
    bus.cancel_en = 1'b1;
    @(negedge clk);
    check("rdy_cancel", bus.v_in_rdy, 0);
    check("seq_err_pre_cancel", bus.seq_err, 1);
    tick();
    clr();
    @(negedge clk);
    check("vld_after_cancel", bus.v_cmt_vld, 0);
    check("rel_en_after_cancel", bus.commit_credit_rel_en, 0);
    check("seq_err_cleared", bus.seq_err, 0);
    tick(3);
    @(negedge clk);
    check("rdy_after_cancel", bus.v_in_rdy, 8'hFF);
    acc(0, 0);
    tick();
    clr();
    cmpl(0, 0);
    tick();
    expect_ret(cyc + 1, 1, 0);
    clr();
    tick(3);
    @(negedge clk);
    check("seq_after_cancel", bus.seq_err, 0);

    // stale and early completions are ignored
    do_reset();
    acc(0, 0);
    tick();
    clr();
    cmpl(0, 32);
    tick();
    clr();
    tick(4);
    cmpl(1, 0);
    tick();
    expect_ret(cyc + 1, 1, 0);
    clr();
    tick(3);
    cmpl(0, 1);
    tick();
    clr();
    acc(0, 1);
    cmpl(1, 1);
    tick();
    clr();
    tick(4);
    cmpl(2, 1);
    tick();
    expect_ret(cyc + 1, 1, 1);
    clr();
    tick(4);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
